// File: rtl/spi_rom_loader_pkg.sv
// Shared types and constants for the SPI ROM loader.
// Build option: define SPI_ROM_LOADER_STREAM_EN to enable sequential-read streaming.
package spi_rom_loader_pkg;

  localparam int         SPI_ADDR_W   = 24;
  localparam int         IMG_ADDR_W   = 21;
  localparam logic [7:0] SPI_CMD_READ = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_SETUP,
    S_CMD,
    S_DATA,
    S_READY,
    S_STREAM,
    S_CS_RELEASE
  } state_t;

  // Byte idx of the 4-byte READ command: opcode, then address MSB first.
  function automatic logic [7:0] cmd_byte(input logic [1:0] idx,
                                          input logic [SPI_ADDR_W-1:0] addr);
    logic [7:0] b;
    case (idx)
      2'd0:    b = SPI_CMD_READ;
      2'd1:    b = addr[23:16];
      2'd2:    b = addr[15:8];
      default: b = addr[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_rom_loader_byte_shifter.sv
// One SPI mode-0 byte: SCK divider plus 8-bit full-duplex shift register.
// A start on the final edge of a byte reloads immediately, so bytes chain
// back to back without an idle cycle.
module spi_byte_shifter #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       sck,
  output logic       mosi,
  output logic [7:0] rx_byte,
  output logic       byte_end,
  output logic       done
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic       busy_reg;
  logic       sck_reg;
  logic       mosi_reg;
  logic       done_reg;
  logic [7:0] div_cnt_reg;
  logic [2:0] bit_idx_reg;
  logic [7:0] tx_sr_reg;
  logic [7:0] rx_sr_reg;
  logic       half_end;

  assign half_end = busy_reg && (div_cnt_reg == DIV_LAST);
  // Falling SCK of bit 7: the byte finishes on this clock edge.
  assign byte_end = half_end && sck_reg && (bit_idx_reg == 3'd7);

  assign sck     = sck_reg;
  assign mosi    = mosi_reg;
  assign rx_byte = rx_sr_reg;
  assign done    = done_reg;

  // Half-period divider, MISO capture on SCK rise, MOSI update on SCK fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg    <= 1'b0;
      sck_reg     <= 1'b0;
      mosi_reg    <= 1'b0;
      done_reg    <= 1'b0;
      div_cnt_reg <= 8'd0;
      bit_idx_reg <= 3'd0;
      tx_sr_reg   <= 8'd0;
      rx_sr_reg   <= 8'd0;
    end else begin
      // A chained start means the next byte is already running; no done.
      done_reg <= byte_end && !start;
      if (start) begin
        busy_reg    <= 1'b1;
        sck_reg     <= 1'b0;
        div_cnt_reg <= 8'd0;
        bit_idx_reg <= 3'd0;
        mosi_reg    <= tx_byte[7];
        tx_sr_reg   <= {tx_byte[6:0], 1'b0};
      end else if (busy_reg) begin
        if (half_end) begin
          div_cnt_reg <= 8'd0;
          if (!sck_reg) begin
            sck_reg   <= 1'b1;
            rx_sr_reg <= {rx_sr_reg[6:0], miso};
          end else begin
            sck_reg <= 1'b0;
            if (bit_idx_reg == 3'd7) begin
              busy_reg <= 1'b0;
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
              mosi_reg    <= tx_sr_reg[7];
              tx_sr_reg   <= {tx_sr_reg[6:0], 1'b0};
            end
          end
        end else begin
          div_cnt_reg <= div_cnt_reg + 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/spi_rom_loader.sv
// Fetches ROM image bytes from a SPI flash with the 0x03 READ command.
// Build option: define SPI_ROM_LOADER_STREAM_EN to keep CS low after a byte
// and serve the next sequential address without reissuing the command.
module spi_rom_loader
  import spi_rom_loader_pkg::*;
#(
  parameter logic [23:0] FLASH_BASE = 24'h100000,
  parameter logic [20:0] IMAGE_LAST = 21'h05FFFF,
  parameter int          CLK_DIV    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_req,
  input  logic [20:0] init_address,
  output logic [7:0]  init_data,
  output logic        init_ready,
  output logic [20:0] init_stop,
  output logic        spi_sck,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam logic [8:0] SETUP_LAST   = 9'(CLK_DIV - 1);
  localparam logic [8:0] RELEASE_LAST = 9'(2 * CLK_DIV - 1);

  state_t                  state_reg;
  logic [8:0]              cnt_reg;
  logic [IMG_ADDR_W-1:0]   addr_reg;
  logic [IMG_ADDR_W-1:0]   pend_addr_reg;
  logic                    pend_reg;
  logic [1:0]              byte_idx_reg;
  logic                    cs_n_reg;
  logic                    ready_reg;
  logic [7:0]              data_reg;

  logic [SPI_ADDR_W-1:0]   flash_addr;
  logic                    sh_start;
  logic [7:0]              sh_tx;
  logic [7:0]              sh_rx;
  logic                    sh_byte_end;
  logic                    sh_done;

  assign flash_addr = FLASH_BASE + {3'b000, addr_reg};

`ifdef SPI_ROM_LOADER_STREAM_EN
  // Next sequential address, with the 21-bit wrap excluded.
  logic seq_hit;
  assign seq_hit = ({1'b0, init_address} == ({1'b0, addr_reg} + 22'd1));
`endif

  assign init_data  = data_reg;
  assign init_ready = ready_reg;
  assign init_stop  = IMAGE_LAST;
  assign spi_cs_n   = cs_n_reg;

  spi_byte_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .start    (sh_start),
    .tx_byte  (sh_tx),
    .miso     (spi_miso),
    .sck      (spi_sck),
    .mosi     (spi_mosi),
    .rx_byte  (sh_rx),
    .byte_end (sh_byte_end),
    .done     (sh_done)
  );

  // Byte launch decode: first opcode, chained command bytes, data bytes (MOSI 0).
  always_comb begin
    sh_start = 1'b0;
    sh_tx    = 8'h00;
    case (state_reg)
      S_CS_SETUP: begin
        if (cnt_reg == SETUP_LAST) begin
          sh_start = 1'b1;
          sh_tx    = SPI_CMD_READ;
        end
      end
      S_CMD: begin
        if (sh_byte_end) begin
          sh_start = 1'b1;
          sh_tx    = (byte_idx_reg == 2'd3) ? 8'h00
                                            : cmd_byte(byte_idx_reg + 2'd1, flash_addr);
        end
      end
`ifdef SPI_ROM_LOADER_STREAM_EN
      S_STREAM: begin
        if (init_req && seq_hit) begin
          sh_start = 1'b1;
        end
      end
`endif
      default: begin
        sh_start = 1'b0;
      end
    endcase
  end

  // Transfer sequencing, chip select and the delivered-byte handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= 9'd0;
      addr_reg      <= '0;
      pend_addr_reg <= '0;
      pend_reg      <= 1'b0;
      byte_idx_reg  <= 2'd0;
      cs_n_reg      <= 1'b1;
      ready_reg     <= 1'b0;
      data_reg      <= 8'h00;
    end else begin
      ready_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (init_req) begin
            addr_reg  <= init_address;
            cs_n_reg  <= 1'b0;
            cnt_reg   <= 9'd0;
            state_reg <= S_CS_SETUP;
          end
        end
        S_CS_SETUP: begin
          if (cnt_reg == SETUP_LAST) begin
            byte_idx_reg <= 2'd0;
            state_reg    <= S_CMD;
          end else begin
            cnt_reg <= cnt_reg + 9'd1;
          end
        end
        S_CMD: begin
          if (sh_byte_end) begin
            if (byte_idx_reg == 2'd3) begin
              state_reg <= S_DATA;
            end else begin
              byte_idx_reg <= byte_idx_reg + 2'd1;
            end
          end
        end
        S_DATA: begin
          if (sh_done) begin
            data_reg  <= sh_rx;
            ready_reg <= 1'b1;
            state_reg <= S_READY;
          end
        end
        S_READY: begin
`ifdef SPI_ROM_LOADER_STREAM_EN
          if (addr_reg == IMAGE_LAST) begin
            cs_n_reg  <= 1'b1;
            cnt_reg   <= 9'd0;
            state_reg <= S_CS_RELEASE;
          end else begin
            state_reg <= S_STREAM;
          end
`else
          cs_n_reg  <= 1'b1;
          cnt_reg   <= 9'd0;
          state_reg <= S_CS_RELEASE;
`endif
        end
`ifdef SPI_ROM_LOADER_STREAM_EN
        S_STREAM: begin
          if (init_req) begin
            if (seq_hit) begin
              addr_reg  <= init_address;
              state_reg <= S_DATA;
            end else begin
              pend_reg      <= 1'b1;
              pend_addr_reg <= init_address;
              cs_n_reg      <= 1'b1;
              cnt_reg       <= 9'd0;
              state_reg     <= S_CS_RELEASE;
            end
          end
        end
`endif
        S_CS_RELEASE: begin
          if (cnt_reg == RELEASE_LAST) begin
            cnt_reg <= 9'd0;
            if (pend_reg) begin
              pend_reg  <= 1'b0;
              addr_reg  <= pend_addr_reg;
              cs_n_reg  <= 1'b0;
              state_reg <= S_CS_SETUP;
            end else begin
              state_reg <= S_IDLE;
            end
          end else begin
            cnt_reg <= cnt_reg + 9'd1;
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_rom_loader.sv
// Directed bench for spi_rom_loader with a behavioural SPI READ flash model.
// Covers both builds of SPI_ROM_LOADER_STREAM_EN.
module tb_spi_rom_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init_req = 1'b0;
  logic [20:0] init_address = 21'd0;
  logic [7:0]  init_data;
  logic        init_ready;
  logic [20:0] init_stop;
  logic        spi_sck;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso = 1'b0;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  spi_rom_loader #(
    .FLASH_BASE (24'h100000),
    .IMAGE_LAST (21'h000003),
    .CLK_DIV    (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .init_req     (init_req),
    .init_address (init_address),
    .init_data    (init_data),
    .init_ready   (init_ready),
    .init_stop    (init_stop),
    .spi_sck      (spi_sck),
    .spi_cs_n     (spi_cs_n),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso)
  );

  // Flash contents: byte at flash address a is a[7:0] ^ 8'hA5.
  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  // Flash model state, sampled on the falling clk edge.
  logic        prev_sck  = 1'b0;
  logic        prev_cs   = 1'b1;
  logic        prev_mosi = 1'b0;
  int          bits = 0;
  logic [31:0] cmd_sr = 32'd0;
  logic [31:0] last_cmd = 32'd0;
  int          cmd_count = 0;
  logic [23:0] rd_addr = 24'd0;
  logic [7:0]  dsr = 8'd0;
  int          cs_rises = 0;
  int          high_run = 0;
  int          last_gap = 0;
  int          mosi_viol = 0;

  // Mode-0 slave: capture MOSI on SCK rise, present MISO on SCK fall.
  always @(negedge clk) begin
    if (spi_mosi !== prev_mosi && spi_sck === 1'b1) mosi_viol++;
    if (spi_cs_n) begin
      if (!prev_cs) cs_rises++;
      high_run++;
      bits = 0;
    end else begin
      if (prev_cs) last_gap = high_run;
      high_run = 0;
      if (spi_sck && !prev_sck) begin
        if (bits < 32) cmd_sr = {cmd_sr[30:0], spi_mosi};
        bits++;
        if (bits == 32) begin
          last_cmd = cmd_sr;
          rd_addr  = cmd_sr[23:0];
          cmd_count++;
        end
      end else if (!spi_sck && prev_sck && bits >= 32) begin
        if ((bits - 32) % 8 == 0) begin
          dsr     = flash_byte(rd_addr);
          rd_addr = rd_addr + 24'd1;
        end
        spi_miso = dsr[7];
        dsr      = {dsr[6:0], 1'b0};
      end
    end
    prev_sck  = spi_sck;
    prev_cs   = spi_cs_n;
    prev_mosi = spi_mosi;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request; latency counts clk edges from the sampling edge to init_ready.
  task automatic do_req(input logic [20:0] a, output int lat,
                        output logic [7:0] d, output logic after);
    @(posedge clk); #1;
    init_req = 1'b1;
    init_address = a;
    @(posedge clk); #1;
    init_req = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (init_ready !== 1'b1 && lat < 400);
    d = init_data;
    @(posedge clk); #1;
    after = init_ready;
    $display("req addr=%06h latency=%0d data=%02h cmd=%08h cmds=%0d", a, lat, d, last_cmd, cmd_count);
  endtask

  int         lat;
  logic [7:0] d;
  logic       after;
  int         rises0;
  int         wait_n;

  initial begin
    tick(3);
    check("rst_cs_n", 32'(spi_cs_n), 32'd1);
    check("rst_sck", 32'(spi_sck), 32'd0);
    check("rst_mosi", 32'(spi_mosi), 32'd0);
    check("rst_ready", 32'(init_ready), 32'd0);
    check("rst_data", 32'(init_data), 32'h00);
    check("init_stop", 32'(init_stop), 32'h000003);
    rst = 1'b0;
    tick(2);

    do_req(21'h000000, lat, d, after);
    check("a0_latency", 32'(lat), 32'd163);
    check("a0_data", 32'(d), 32'hA5);
    check("a0_ready_pulse", 32'(after), 32'd0);
    check("a0_cmd", last_cmd, 32'h03100000);
    check("a0_cmd_count", 32'(cmd_count), 32'd1);

`ifdef SPI_ROM_LOADER_STREAM_EN
    rises0 = cs_rises;
    do_req(21'h000001, lat, d, after);
    check("s1_latency", 32'(lat), 32'd33);
    check("s1_data", 32'(d), 32'hA4);
    check("s1_ready_pulse", 32'(after), 32'd0);
    tick(20);
    do_req(21'h000002, lat, d, after);
    check("s2_latency", 32'(lat), 32'd33);
    check("s2_data", 32'(d), 32'hA7);
    check("s2_no_cs_rise", 32'(cs_rises), 32'(rises0));
    check("s2_cmd_count", 32'(cmd_count), 32'd1);

    do_req(21'h000010, lat, d, after);
    check("n10_latency", 32'(lat), 32'd167);
    check("n10_data", 32'(d), 32'hB5);
    check("n10_cs_gap", 32'(last_gap), 32'd4);
    check("n10_cmd", last_cmd, 32'h03100010);
    check("n10_cmd_count", 32'(cmd_count), 32'd2);

    do_req(21'h000003, lat, d, after);
    check("e3_latency", 32'(lat), 32'd167);
    check("e3_data", 32'(d), 32'hA6);
    check("e3_cmd", last_cmd, 32'h03100003);
`else
    tick(8);
    do_req(21'h000001, lat, d, after);
    check("f1_latency", 32'(lat), 32'd163);
    check("f1_data", 32'(d), 32'hA4);
    check("f1_cmd", last_cmd, 32'h03100001);
    check("f1_cmd_count", 32'(cmd_count), 32'd2);
    check("f1_cs_gap_ge4", 32'(last_gap >= 4), 32'd1);

    tick(8);
    do_req(21'h000003, lat, d, after);
    check("e3_latency", 32'(lat), 32'd163);
    check("e3_data", 32'(d), 32'hA6);
    check("e3_cmd", last_cmd, 32'h03100003);
`endif

    // Image end reached: chip select released and the FSM back in idle.
    tick(8);
    check("end_cs_n", 32'(spi_cs_n), 32'd1);
    check("end_sck", 32'(spi_sck), 32'd0);

    // Reset during the 20th command bit.
    @(posedge clk); #1;
    init_req = 1'b1;
    init_address = 21'h000005;
    @(posedge clk); #1;
    init_req = 1'b0;
    wait_n = 0;
    while (!(bits == 19 && spi_sck === 1'b0) && wait_n < 300) begin
      @(posedge clk); #1;
      wait_n++;
    end
    check("rst_bit20_reached", 32'(wait_n < 300), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_cs_n", 32'(spi_cs_n), 32'd1);
    check("abort_sck", 32'(spi_sck), 32'd0);
    check("abort_ready", 32'(init_ready), 32'd0);
    $display("reset applied at command bit %0d", bits + 1);
    rst = 1'b0;
    tick(3);

    do_req(21'h000006, lat, d, after);
    check("r6_latency", 32'(lat), 32'd163);
    check("r6_data", 32'(d), 32'hA3);
    check("r6_cmd", last_cmd, 32'h03100006);

    check("mosi_stable_sck_high", 32'(mosi_viol), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/spi_rom_loader.md
SPI_ROM_LOADER -- requirements
Module: spi_rom_loader

Interface
REQ-001 Parameter FLASH_BASE, 24'h100000, flash byte offset of the ROM image.
REQ-002 Parameter IMAGE_LAST, 21'h05FFFF, last image byte address, driven on init_stop.
REQ-003 Parameter CLK_DIV, 2, SCK half-period in clk cycles; legal range 1..255.
REQ-004 clk  in  1  sole clock; all logic rising-edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 init_req  in  1  one-cycle pulse requesting the byte at init_address.
REQ-007 init_address  in  21  image byte address; sampled on the init_req cycle.
REQ-008 init_data  out  8  fetched byte; valid from the init_ready cycle until the next init_ready.
REQ-009 init_ready  out  1  one-cycle pulse, byte available.
REQ-010 init_stop  out  21  constant IMAGE_LAST.
REQ-011 spi_sck / spi_cs_n / spi_mosi  out  1 each  SPI mode 0 master.
REQ-012 spi_miso  in  1  flash serial data.

Function
REQ-013 Flash address = FLASH_BASE + init_address, zero-extended to 24 bits, modulo 2^24.
REQ-014 FSM states: S_IDLE, S_CS_SETUP, S_CMD, S_DATA, S_READY, S_STREAM, S_CS_RELEASE.
REQ-015 S_IDLE, init_req -> latch address, drive spi_cs_n low, go to S_CS_SETUP.
REQ-016 S_CS_SETUP lasts CLK_DIV cycles, then S_CMD.
REQ-017 S_CMD shifts 32 bits MSB first: opcode 8'h03, then the 24-bit flash address.
REQ-018 MOSI changes only while SCK low; MISO is sampled on SCK rising edges; SCK idles low.
REQ-019 S_DATA shifts 8 bits in, MSB first; MOSI is held 0 during S_DATA.
REQ-020 The cycle after the 8th MISO sample: init_data updated, init_ready=1 for exactly one cycle (S_READY).
REQ-021 From S_READY: if the delivered address == IMAGE_LAST -> S_CS_RELEASE; otherwise -> S_STREAM, spi_cs_n held low, SCK stopped low.
REQ-022 S_STREAM, init_req with init_address == last+1 (21-bit, no wrap) -> S_DATA directly; no command is reissued.
REQ-023 S_STREAM, init_req with any other address -> S_CS_RELEASE; that request is retained and serviced next.
REQ-024 S_CS_RELEASE holds spi_cs_n high for 2*CLK_DIV cycles, then goes to S_CS_SETUP if a request is pending, else to S_IDLE.
REQ-025 init_req outside S_IDLE/S_STREAM is ignored and produces no init_ready.
REQ-026 S_STREAM has no timeout; an arbitrarily long gap (refresh stalls) is legal.
REQ-027 Fresh-command latency, init_req to init_ready: CLK_DIV + 80*CLK_DIV + 1 cycles.
REQ-028 Streamed latency: 16*CLK_DIV + 1 cycles.

Reset
REQ-029 On rst: spi_cs_n=1, spi_sck=0, spi_mosi=0, init_ready=0, init_data=8'h00, state=S_IDLE, no pending request.
REQ-030 rst mid-transfer aborts immediately; the next post-reset request issues a fresh command.

Configuration
REQ-031 Macro SPI_ROM_LOADER_STREAM_EN defined: streaming per REQ-021/022.
REQ-032 Macro SPI_ROM_LOADER_STREAM_EN undefined: S_READY always goes to S_CS_RELEASE, every byte issues a full command, and S_STREAM is not synthesized.

Structure
REQ-033 Package spi_rom_loader_pkg holds the state enum, SPI_CMD_READ = 8'h03 and SPI_ADDR_W = 24.
REQ-034 Sub-module spi_byte_shifter holds the CLK_DIV divider and an 8-bit full-duplex shift; the parent chains 4 command bytes and 1 data byte.

Verification
REQ-035 CLK_DIV=2, FLASH_BASE=24'h100000, req addr 0, flash model 0xA5 -> MOSI 03 10 00 00, init_data=A5, init_ready once at cycle 163.
REQ-036 Stream: reqs 0x000001, 0x000002 after REQ-035 -> no CS rise and no new opcode; each init_ready arrives 33 cycles after its req.
REQ-037 Non-sequential: req 0x000010 while streaming at 0x000002 -> CS high for 4 cycles, then command with address 0x100010.
REQ-038 End of image: IMAGE_LAST=0x000003, deliver 0x000003 -> spi_cs_n=1 after S_CS_RELEASE, FSM in S_IDLE.
REQ-039 rst asserted during the 20th command bit -> the next cycle shows spi_cs_n=1, spi_sck=0, init_ready=0; the next req restarts with opcode 03.
REQ-040 Macro undefined, reqs 0 then 1 -> two full commands separated by a CS-high gap of at least 4 cycles.
